// File: rtl/spi_reg_sequencer_if.sv
// Signal bundle between the SPI frame shifter, local fabric writers and the
// register sequencer. The bench or shifter side uses master; the sequencer uses slave.
interface spi_reg_sequencer_if #(
   parameter int ADDR_W = 4
);
   localparam int NREG = 2**ADDR_W;

   logic                 frame_valid;
   logic [15:0]          frame_data;
   logic [15:0]          tx_word;
   logic                 hw_we;
   logic [ADDR_W-1:0]    hw_addr;
   logic [15:0]          hw_wdata;
   logic                 hw_ready;
   logic [16*NREG-1:0]   reg_out;
   logic                 busy;
   logic [1:0]           err;

   modport master (
      output frame_valid, frame_data, hw_we, hw_addr, hw_wdata,
      input  tx_word, hw_ready, reg_out, busy, err
   );

   modport slave (
      input  frame_valid, frame_data, hw_we, hw_addr, hw_wdata,
      output tx_word, hw_ready, reg_out, busy, err
   );
endinterface

// File: rtl/spi_reg_sequencer.sv
// Decodes 16-bit SPI frames into burst reads/writes of a 16-bit register bank,
// shares the bank write port with local fabric and supplies the next reply word.
module spi_reg_sequencer #(
   parameter int         ADDR_W     = 4,
   parameter int         TIMEOUT    = 48000,
   parameter logic [7:0] STATUS_TAG = 8'hA5
) (
   input logic                clk,
   input logic                rst,
   spi_reg_sequencer_if.slave bus
);
   localparam int NREG = 2**ADDR_W;
   localparam int TW   = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WDATA, RDATA} state_t;

   state_t                  r_state, w_stateNext;
   logic [NREG-1:0][15:0]   r_regs;
   logic [ADDR_W-1:0]       r_ptr, w_ptrNext;
   logic [4:0]              r_remaining, w_remainingNext;
   logic                    r_inc, w_incNext;
   logic [TW-1:0]           r_timer, w_timerNext;
   logic [1:0]              r_err, w_errNext;
   logic [15:0]             r_tx, w_txNext;

   logic [1:0]              w_op;
   logic [4:0]              w_len;
   logic [ADDR_W-1:0]       w_hdrAddr;
   logic [ADDR_W-1:0]       w_ptrAdv;
   logic [ADDR_W-1:0]       w_rdAddr;
   logic [15:0]             w_rdData;
   logic                    w_spiWe;
   logic                    w_hwCommit;

   assign w_op      = bus.frame_data[13:12];
   assign w_len     = {1'b0, bus.frame_data[11:8]} + 5'd1;
   assign w_hdrAddr = bus.frame_data[ADDR_W-1:0];
   assign w_ptrAdv  = r_inc ? r_ptr + ADDR_W'(1) : r_ptr;

   assign w_spiWe      = bus.frame_valid && (r_state == WDATA);
   assign bus.hw_ready = !w_spiWe;
   assign w_hwCommit   = bus.hw_we && bus.hw_ready;

   // Read data forwards a same-cycle local write so the reply sees the newest value.
   assign w_rdAddr = (r_state == IDLE) ? w_hdrAddr : w_ptrAdv;
   assign w_rdData = (w_hwCommit && (bus.hw_addr == w_rdAddr)) ? bus.hw_wdata : r_regs[w_rdAddr];

   assign bus.reg_out = r_regs;
   assign bus.tx_word = r_tx;
   assign bus.busy    = (r_state != IDLE);
   assign bus.err     = r_err;

   // Single bank write port: an SPI data word wins, a blocked local write retries later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_regs <= '0;
      end else if (w_spiWe) begin
         r_regs[r_ptr] <= bus.frame_data;
      end else if (w_hwCommit) begin
         r_regs[bus.hw_addr] <= bus.hw_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_remaining <= '0;
         r_inc       <= 1'b0;
         r_timer     <= '0;
         r_err       <= 2'b00;
         r_tx        <= {STATUS_TAG, 8'h00};
      end else begin
         r_state     <= w_stateNext;
         r_ptr       <= w_ptrNext;
         r_remaining <= w_remainingNext;
         r_inc       <= w_incNext;
         r_timer     <= w_timerNext;
         r_err       <= w_errNext;
         r_tx        <= w_txNext;
      end
   end

   // Header decode, burst sequencing and the inter-frame watchdog.
   always_comb begin
      w_stateNext     = r_state;
      w_ptrNext       = r_ptr;
      w_remainingNext = r_remaining;
      w_incNext       = r_inc;
      w_timerNext     = '0;
      w_errNext       = r_err;
      w_txNext        = r_tx;
      case (r_state)
         IDLE: begin
            if (bus.frame_valid) begin
               case (w_op)
                  2'b00: begin
                     w_ptrNext       = w_hdrAddr;
                     w_remainingNext = w_len;
                     w_incNext       = bus.frame_data[14];
                     w_stateNext     = bus.frame_data[15] ? WDATA : RDATA;
                  end
                  2'b11:   w_errNext    = 2'b00;
                  default: w_errNext[1] = 1'b1;
               endcase
            end
         end
         WDATA, RDATA: begin
            if (bus.frame_valid) begin
               w_ptrNext       = w_ptrAdv;
               w_remainingNext = r_remaining - 5'd1;
               if (r_remaining == 5'd1) begin
                  w_stateNext = IDLE;
               end
            end else if (r_timer == TMAX) begin
               w_stateNext  = IDLE;
               w_errNext[0] = 1'b1;
            end else begin
               w_timerNext = r_timer + TW'(1);
            end
         end
         default: w_stateNext = IDLE;
      endcase
      // Outside a read burst the reply is always the status word of the coming cycle.
      if (w_stateNext != RDATA) begin
         w_txNext = {STATUS_TAG, 6'b000000, w_errNext};
      end else if (bus.frame_valid) begin
         w_txNext = w_rdData;
      end
   end
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed and randomized bursts against a burst-level model of the register bank,
// error flags and reply word.
module tb_spi_reg_sequencer;
   localparam int TIMEOUT = 48000;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   logic [15:0] modelRegs [16];
   logic [1:0]  modelErr;
   logic [15:0] wrData [16];

   spi_reg_sequencer_if #(.ADDR_W(4)) bus ();

   spi_reg_sequencer #(
      .ADDR_W(4),
      .TIMEOUT(TIMEOUT),
      .STATUS_TAG(8'hA5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] packRegs();
      logic [255:0] r;
      for (int i = 0; i < 16; i++) r[16*i +: 16] = modelRegs[i];
      return r;
   endfunction

   function automatic logic [15:0] statusWord();
      return {8'hA5, 6'b000000, modelErr};
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock with a frame pulse and optional local write in the same cycle.
   task automatic applyStimulus(input logic [15:0] fd, input logic we, input logic [3:0] wa,
                                input logic [15:0] wd);
      bus.frame_valid = 1'b1;
      bus.frame_data  = fd;
      bus.hw_we       = we;
      bus.hw_addr     = wa;
      bus.hw_wdata    = wd;
      tick();
      bus.frame_valid = 1'b0;
      bus.hw_we       = 1'b0;
   endtask

   task automatic hwWrite(input logic [3:0] wa, input logic [15:0] wd);
      bus.hw_we    = 1'b1;
      bus.hw_addr  = wa;
      bus.hw_wdata = wd;
      tick();
      bus.hw_we = 1'b0;
      modelRegs[wa] = wd;
   endtask

   function automatic logic [15:0] makeHeader(input bit wr, input bit inc, input int len, input int addr);
      logic [3:0] junk;
      junk = 4'($urandom_range(0, 15));
      return {wr, inc, 2'b00, 4'(len - 1), junk, 4'(addr)};
   endfunction

   // Write burst of wrData[0..len-1]; data lands at (addr + k*inc) mod 16.
   task automatic writeBurst(input int addr, input int len, input bit inc, input bit gaps);
      applyStimulus(makeHeader(1'b1, inc, len, addr), 1'b0, 4'd0, 16'd0);
      checkOutput("wr hdr busy", bus.busy, 1);
      for (int k = 0; k < len; k++) begin
         if (gaps) repeat ($urandom_range(0, 3)) tick();
         applyStimulus(wrData[k], 1'b0, 4'd0, 16'd0);
         modelRegs[(addr + (inc ? k : 0)) % 16] = wrData[k];
      end
      checkOutput("wr end busy", bus.busy, 0);
      checkOutput("wr end regs", bus.reg_out, packRegs());
      checkOutput("wr end tx", bus.tx_word, statusWord());
   endtask

   // Read burst; optionally a local write lands on the next word in the advancing cycle.
   task automatic readBurst(input int addr, input int len, input bit inc, input bit raw);
      int         nxt;
      logic       we;
      logic [15:0] wd;
      applyStimulus(makeHeader(1'b0, inc, len, addr), 1'b0, 4'd0, 16'd0);
      checkOutput("rd hdr tx", bus.tx_word, modelRegs[addr]);
      for (int k = 1; k <= len; k++) begin
         repeat ($urandom_range(0, 2)) tick();
         nxt = (addr + (inc ? k : 0)) % 16;
         we  = raw && (k < len) && ($urandom_range(0, 1) == 1);
         wd  = 16'($urandom());
         if (we) modelRegs[nxt] = wd;
         applyStimulus(16'($urandom()), we, 4'(nxt), wd);
         checkOutput("rd adv tx", bus.tx_word, (k < len) ? modelRegs[nxt] : statusWord());
      end
      checkOutput("rd end busy", bus.busy, 0);
   endtask

   initial begin
      int rAddr, rLen;
      bit rInc;
      for (int i = 0; i < 16; i++) modelRegs[i] = 16'h0000;
      modelErr        = 2'b00;
      bus.frame_valid = 1'b1;
      bus.frame_data  = 16'hC000;
      bus.hw_we       = 1'b0;
      bus.hw_addr     = 4'd0;
      bus.hw_wdata    = 16'd0;
      rst             = 1'b1;
      $display("[TB] reset with frame_valid held high");
      repeat (3) tick();
      rst             = 1'b0;
      bus.frame_valid = 1'b0;
      tick();
      checkOutput("reset tx", bus.tx_word, 16'hA500);
      checkOutput("reset regs", bus.reg_out, 0);
      checkOutput("reset busy", bus.busy, 0);
      checkOutput("reset err", bus.err, 0);
      checkOutput("reset hw_ready", bus.hw_ready, 1);

      $display("[TB] directed write burst C203");
      applyStimulus(16'hC203, 1'b0, 4'd0, 16'd0);
      applyStimulus(16'h1111, 1'b0, 4'd0, 16'd0);
      applyStimulus(16'h2222, 1'b0, 4'd0, 16'd0);
      checkOutput("c203 busy mid", bus.busy, 1);
      applyStimulus(16'h3333, 1'b0, 4'd0, 16'd0);
      modelRegs[3] = 16'h1111;
      modelRegs[4] = 16'h2222;
      modelRegs[5] = 16'h3333;
      checkOutput("c203 busy end", bus.busy, 0);
      checkOutput("c203 regs", bus.reg_out, packRegs());
      checkOutput("c203 tx", bus.tx_word, 16'hA500);

      $display("[TB] directed read with wrap 410F");
      hwWrite(4'd15, 16'hABCD);
      hwWrite(4'd0, 16'h1234);
      applyStimulus(16'h410F, 1'b0, 4'd0, 16'd0);
      checkOutput("410f hdr tx", bus.tx_word, 16'hABCD);
      repeat (2) tick();
      checkOutput("410f hold tx", bus.tx_word, 16'hABCD);
      applyStimulus(16'h0000, 1'b0, 4'd0, 16'd0);
      checkOutput("410f 1st tx", bus.tx_word, 16'h1234);
      applyStimulus(16'h0000, 1'b0, 4'd0, 16'd0);
      checkOutput("410f 2nd tx", bus.tx_word, 16'hA500);
      checkOutput("410f busy", bus.busy, 0);

      $display("[TB] burst timeout");
      applyStimulus(16'hC101, 1'b0, 4'd0, 16'd0);
      applyStimulus(16'h0BEE, 1'b0, 4'd0, 16'd0);
      modelRegs[1] = 16'h0BEE;
      repeat (TIMEOUT - 1) tick();
      checkOutput("timeout early busy", bus.busy, 1);
      tick();
      modelErr = 2'b01;
      checkOutput("timeout busy", bus.busy, 0);
      checkOutput("timeout err", bus.err, 2'b01);
      checkOutput("timeout tx", bus.tx_word, 16'hA501);
      checkOutput("timeout regs", bus.reg_out, packRegs());
      applyStimulus(16'h3000, 1'b0, 4'd0, 16'd0);
      modelErr = 2'b00;
      checkOutput("clear err", bus.err, 2'b00);
      checkOutput("clear tx", bus.tx_word, 16'hA500);

      $display("[TB] bad op headers");
      applyStimulus(16'h1000, 1'b0, 4'd0, 16'd0);
      modelErr = 2'b10;
      checkOutput("badop busy", bus.busy, 0);
      checkOutput("badop err", bus.err, 2'b10);
      checkOutput("badop tx", bus.tx_word, 16'hA502);
      checkOutput("badop regs", bus.reg_out, packRegs());
      applyStimulus(16'hE5A7, 1'b0, 4'd0, 16'd0);
      checkOutput("badop2 busy", bus.busy, 0);
      checkOutput("badop2 regs", bus.reg_out, packRegs());
      applyStimulus(16'h3000, 1'b0, 4'd0, 16'd0);
      modelErr = 2'b00;
      checkOutput("clear2 tx", bus.tx_word, 16'hA500);

      $display("[TB] write port collision");
      applyStimulus(16'h8002, 1'b0, 4'd0, 16'd0);
      bus.frame_valid = 1'b1;
      bus.frame_data  = 16'h7777;
      bus.hw_we       = 1'b1;
      bus.hw_addr     = 4'd2;
      bus.hw_wdata    = 16'h5555;
      #1;
      checkOutput("collide hw_ready", bus.hw_ready, 0);
      @(posedge clk);
      #1;
      bus.frame_valid = 1'b0;
      #1;
      checkOutput("collide spi first", bus.reg_out[47:32], 16'h7777);
      checkOutput("collide hw_ready after", bus.hw_ready, 1);
      tick();
      bus.hw_we = 1'b0;
      modelRegs[2] = 16'h5555;
      checkOutput("collide local last", bus.reg_out, packRegs());

      $display("[TB] randomized bursts");
      for (int n = 0; n < 24; n++) begin
         rAddr = $urandom_range(0, 15);
         rLen  = $urandom_range(1, 16);
         rInc  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 16; k++) wrData[k] = 16'($urandom());
            writeBurst(rAddr, rLen, rInc, 1'b1);
         end else begin
            if ($urandom_range(0, 1) == 1) hwWrite(4'($urandom_range(0, 15)), 16'($urandom()));
            readBurst(rAddr, rLen, rInc, 1'b1);
         end
      end
      checkOutput("random regs", bus.reg_out, packRegs());

      $display("[TB] reset in the middle of a read burst");
      applyStimulus(16'h2000, 1'b0, 4'd0, 16'd0);
      modelErr = 2'b10;
      checkOutput("pre-reset err", bus.err, 2'b10);
      applyStimulus(16'h4303, 1'b0, 4'd0, 16'd0);
      applyStimulus(16'h0000, 1'b0, 4'd0, 16'd0);
      checkOutput("pre-reset busy", bus.busy, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst tx", bus.tx_word, 16'hA500);
      checkOutput("async rst regs", bus.reg_out, 0);
      checkOutput("async rst busy", bus.busy, 0);
      checkOutput("async rst err", bus.err, 0);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("post-reset busy", bus.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
